// File: rtl/proc_top.sv
// Minimal 8-bit processor system: 64 KiB unified memory (u0) plus a multi-cycle
// CPU (u1) that runs from address 0x0000 until HLT and then holds a sticky halt.

module proc_mem #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign rdata = mem[addr];

  // Byte write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end
endmodule

module proc_cpu #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic [DATA_W-1:0] wdata
);
  typedef enum logic [2:0] {FETCH, OPLO, OPHI, EXEC, HALT} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir, lo, hi;
  logic [DATA_W-1:0] RF [0:3];
  logic [4:0]        flags, flags_nx;
  logic              halt;

  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [7:0] a, b, opnd, res;
  logic [8:0] sum9, diff9;
  logic       cy, ov, arith, rf_we, jmp;

  // Number of operand bytes that follow an opcode.
  function automatic logic [1:0] op_len(input logic [3:0] o);
    case (o)
      4'h2:                op_len = 2'd1;
      4'h3, 4'h4, 4'hB:    op_len = 2'd2;
      default:             op_len = 2'd0;
    endcase
  endfunction

  assign op   = ir[7:4];
  assign rd   = ir[3:2];
  assign rs   = ir[1:0];
  assign a    = RF[rd];
  assign b    = RF[rs];
  assign opnd = (op == 4'hC) ? 8'h01 : b;
  assign sum9  = {1'b0, a} + {1'b0, opnd};
  assign diff9 = {1'b0, a} - {1'b0, opnd};

  // Execute-stage datapath: result, flag update, writeback and jump decisions.
  always_comb begin
    res      = 8'h00;
    cy       = 1'b0;
    ov       = 1'b0;
    arith    = 1'b0;
    rf_we    = 1'b0;
    jmp      = 1'b0;
    flags_nx = flags;
    case (op)
      4'h1: begin res = b;     rf_we = 1'b1; end
      4'h2: begin res = lo;    rf_we = 1'b1; end
      4'h3: begin res = rdata; rf_we = 1'b1; end
      4'h5: begin
        res = sum9[7:0]; cy = sum9[8]; arith = 1'b1; rf_we = 1'b1;
        ov = (a[7] == opnd[7]) && (sum9[7] != a[7]);
      end
      4'h6, 4'hA: begin
        res = diff9[7:0]; cy = diff9[8]; arith = 1'b1; rf_we = (op == 4'h6);
        ov = (a[7] != opnd[7]) && (diff9[7] != a[7]);
      end
      4'h7: begin res = a & b; arith = 1'b1; rf_we = 1'b1; end
      4'h8: begin res = a | b; arith = 1'b1; rf_we = 1'b1; end
      4'h9: begin res = a ^ b; arith = 1'b1; rf_we = 1'b1; end
      4'hB: begin
        case (rd)
          2'b00:   jmp = 1'b1;
          2'b01:   jmp = flags[0];
          2'b10:   jmp = ~flags[0];
          2'b11:   jmp = flags[1];
          default: jmp = 1'b0;
        endcase
      end
      4'hC: begin
        arith = 1'b1; rf_we = 1'b1;
        case (rs)
          2'b00: begin
            res = sum9[7:0]; cy = sum9[8];
            ov = (a[7] == opnd[7]) && (sum9[7] != a[7]);
          end
          2'b01: begin
            res = diff9[7:0]; cy = diff9[8];
            ov = (a[7] != opnd[7]) && (diff9[7] != a[7]);
          end
          2'b10:   begin res = {a[6:0], 1'b0}; cy = a[7]; end
          2'b11:   begin res = {1'b0, a[7:1]}; cy = a[0]; end
          default: begin res = 8'h00; cy = 1'b0; end
        endcase
      end
      4'hD: flags_nx[4] = rs[0];
      default: begin end
    endcase
    if (arith) begin
      flags_nx[3:0] = {res[7], ov, cy, (res == 8'h00)};
    end else begin
      flags_nx[3:0] = flags[3:0];
    end
  end

  // Memory port: LD/ST use the operand address during EXEC, otherwise PC.
  always_comb begin
    if ((state == EXEC) && ((op == 4'h3) || (op == 4'h4))) begin
      addr = {hi, lo};
    end else begin
      addr = pc;
    end
    we    = (state == EXEC) && (op == 4'h4);
    wdata = RF[rd];
  end

  // Next-state logic: one memory byte per cycle.
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = (op_len(rdata[7:4]) == 2'd0) ? EXEC : OPLO;
      OPLO:    state_nx = (op_len(op) == 2'd2) ? OPHI : EXEC;
      OPHI:    state_nx = EXEC;
      EXEC:    state_nx = (op == 4'hF) ? HALT : FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= 16'h0000;
      ir    <= 8'h00;
      lo    <= 8'h00;
      hi    <= 8'h00;
      flags <= 5'b00000;
      halt  <= 1'b0;
      for (int i = 0; i < 4; i++) RF[i] <= 8'h00;
    end else begin
      state <= state_nx;
      case (state)
        FETCH: begin ir <= rdata; pc <= pc + 16'h0001; end
        OPLO:  begin lo <= rdata; pc <= pc + 16'h0001; end
        OPHI:  begin hi <= rdata; pc <= pc + 16'h0001; end
        EXEC: begin
          if (rf_we) RF[rd] <= res;
          flags <= flags_nx;
          if (jmp) pc <= {hi, lo};
          if (op == 4'hF) halt <= 1'b1;
        end
        HALT:    halt <= 1'b1;
        default: halt <= halt;
      endcase
    end
  end
endmodule

module proc_top #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input logic clk_i,
  input logic rst_i
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata, mem_wdata;
  logic              mem_we;

  proc_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u0 (
    .clk(clk_i), .addr(mem_addr), .we(mem_we), .wdata(mem_wdata), .rdata(mem_rdata)
  );

  proc_cpu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u1 (
    .clk(clk_i), .rst(rst_i), .rdata(mem_rdata),
    .addr(mem_addr), .we(mem_we), .wdata(mem_wdata)
  );
endmodule

// File: tb/tb_proc_top.sv
// Table-driven program runs for proc_top; expected end states are queued at
// reset release and compared when halt is observed.

module tb_proc_top;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  proc_top dut (.clk_i(clk_i), .rst_i(rst_i));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [0:15][7:0] prog;
    logic [7:0]       len;
    logic [15:0]      pa;
    logic [7:0]       pd;
    logic [7:0]       ea, eb, ec, ed;
    logic [4:0]       ef;
    logic [15:0]      maddr;
    logic [7:0]       mdata;
    logic [15:0]      cyc;
  } vec_t;

  vec_t vecs [0:6];
  vec_t sb_q [$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [0:15][7:0] p(input logic [127:0] x, input int n);
    return x << (8 * (16 - n));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 65536; i++) dut.u0.mem[i] = 8'h00;
    dut.u0.mem[v.pa] = v.pd;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(v.len)) dut.u0.mem[i] = v.prog[i];
    end
  endtask

  // Waits for halt (bounded), pops the expected record and compares.
  task automatic wait_and_check(input string tag);
    int   cyc;
    vec_t e;
    cyc = 0;
    while (!dut.u1.halt && cyc < 500) begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
    end
    e = sb_q.pop_front();
    chk({tag, ".cycles"}, cyc, {16'h0000, e.cyc});
    chk({tag, ".halt"},  {31'd0, dut.u1.halt}, 32'd1);
    chk({tag, ".A"},     {24'd0, dut.u1.RF[0]}, {24'd0, e.ea});
    chk({tag, ".B"},     {24'd0, dut.u1.RF[1]}, {24'd0, e.eb});
    chk({tag, ".C"},     {24'd0, dut.u1.RF[2]}, {24'd0, e.ec});
    chk({tag, ".D"},     {24'd0, dut.u1.RF[3]}, {24'd0, e.ed});
    chk({tag, ".flags"}, {27'd0, dut.u1.flags}, {27'd0, e.ef});
    chk({tag, ".mem"},   {24'd0, dut.u0.mem[e.maddr]}, {24'd0, e.mdata});
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    rst_i = 1'b1;
    @(negedge clk_i);
    load(v);
    @(negedge clk_i);
    rst_i = 1'b0;
    sb_q.push_back(v);
    wait_and_check(tag);
  endtask

  initial begin
    // {prog, len, preset addr, preset data, A, B, C, D, flags(IF S V C Z), mem addr, mem data, cycles}
    vecs[0] = '{p({8'h20,8'hF8,8'h24,8'h18,8'h51,8'h24,8'h02,8'hF0}, 8), 8'd8,
                16'h8000, 8'h00, 8'h10, 8'h02, 8'h00, 8'h00, 5'b00010, 16'h0000, 8'h20, 16'd13};
    vecs[1] = '{p({8'h24,8'h05,8'h44,8'h00,8'h01,8'hF0}, 6), 8'd6,
                16'h8000, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 5'b00000, 16'h0100, 8'h05, 16'd9};
    vecs[2] = '{p({8'h28,8'h03,8'hC9,8'hB8,8'h02,8'h00,8'hF0}, 7), 8'd7,
                16'h8000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00001, 16'h0000, 8'h28, 16'd23};
    vecs[3] = '{p({8'h20,8'h80,8'h24,8'h01,8'h61,8'hF0}, 6), 8'd6,
                16'h8000, 8'h00, 8'h7F, 8'h01, 8'h00, 8'h00, 5'b00100, 16'h0000, 8'h20, 16'd10};
    vecs[4] = '{p({8'h3C,8'h00,8'h02,8'h20,8'hF0,8'h83,8'hD1,8'hF0}, 8), 8'd8,
                16'h0200, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h0F, 5'b11000, 16'h0200, 8'h0F, 16'd13};
    // PC wrap: jump to 0xFFFF where LDI A takes its immediate from 0x0000.
    vecs[5] = '{p({8'hB0,8'hFF,8'hFF}, 3), 8'd3,
                16'hFFFF, 8'h20, 8'hB0, 8'h00, 8'h00, 8'h00, 5'b00000, 16'hFFFF, 8'h20, 16'd9};
    // Store overwrites a not-yet-fetched NOP with HLT; LDI B is never reached.
    vecs[6] = '{p({8'h20,8'hF0,8'h40,8'h05,8'h00,8'h00,8'h24,8'h77,8'hF0}, 9), 8'd9,
                16'h8000, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00, 5'b00000, 16'h0005, 8'hF0, 16'd9};

    #2;
    chk("reset.halt",  {31'd0, dut.u1.halt}, 32'd0);
    chk("reset.flags", {27'd0, dut.u1.flags}, 32'd0);
    chk("reset.A",     {24'd0, dut.u1.RF[0]}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // MOV/SHL/SHR/AND/XOR/CMP chain.
    run_vec('{p({8'h20,8'h81,8'h14,8'hC6,8'hC3,8'h71,8'h94,8'hA1,8'hF0}, 9), 8'd9,
              16'h8000, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 5'b01010, 16'h0000, 8'h20, 16'd17},
            "alu");

    // Halt is sticky: nothing changes over further cycles.
    repeat (6) @(negedge clk_i);
    chk("sticky.halt", {31'd0, dut.u1.halt}, 32'd1);
    chk("sticky.B",    {24'd0, dut.u1.RF[1]}, 32'h02);

    // Asynchronous reset mid-loop, then rerun from retained memory.
    rst_i = 1'b1;
    @(negedge clk_i);
    load(vecs[2]);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("mid.C_before", {24'd0, dut.u1.RF[2]}, 32'h02);
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("mid.C",     {24'd0, dut.u1.RF[2]}, 32'h00);
    chk("mid.flags", {27'd0, dut.u1.flags}, 32'd0);
    chk("mid.halt",  {31'd0, dut.u1.halt}, 32'd0);
    chk("mid.mem0",  {24'd0, dut.u0.mem[0]}, 32'h28);
    @(negedge clk_i);
    rst_i = 1'b0;
    sb_q.push_back(vecs[2]);
    wait_and_check("rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
